// File: rtl/gate_scheduler_pkg.sv
// Shared types and constants for the parking-lot barrier scheduler.
package gate_scheduler_pkg;

   localparam int NUM_SPOTS = 4;
   localparam int SPOT_W    = 2;
   localparam int CNT_W     = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      G_ENTER = 2'd1,
      G_EXIT  = 2'd2,
      DOOR    = 2'd3
   } state_e;

   localparam logic GRANT_ENTER = 1'b0;
   localparam logic GRANT_EXIT  = 1'b1;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SPOTS-1:0] v);
      logic [CNT_W-1:0] n;
      n = 3'd0;
      for (int i = 0; i < NUM_SPOTS; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gate_scheduler_free_spot_enc.sv
// Lowest-numbered free spot finder: priority encoder over the occupancy vector.
module gate_scheduler_free_spot_enc
   import gate_scheduler_pkg::*;
(
   input  logic [NUM_SPOTS-1:0] spot_busy_i,
   output logic                 valid_o,
   output logic [SPOT_W-1:0]    index_o
);

   logic              valid_s;
   logic [SPOT_W-1:0] index_s;

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      valid_s = 1'b0;
      index_s = {SPOT_W{1'b0}};
      for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
         index_s = spot_busy_i[i] ? index_s : SPOT_W'(i);
         valid_s = valid_s | ~spot_busy_i[i];
      end
   end

   assign valid_o = valid_s;
   assign index_o = index_s;

endmodule

// File: rtl/gate_scheduler.sv
// Barrier door arbiter: grants entry/exit round-robin, tracks spot occupancy, times the door.
module gate_scheduler
   import gate_scheduler_pkg::*;
#(
   parameter int unsigned DOOR_HOLD = 8
)
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 enter_req,
   input  logic                 exit_req,
   input  logic [SPOT_W-1:0]    exit_spot,
   output logic                 enter_ack,
   output logic [SPOT_W-1:0]    assigned_spot,
   output logic                 exit_ack,
   output logic                 exit_err,
   output logic [NUM_SPOTS-1:0] spot_busy,
   output logic [NUM_SPOTS-1:0] spot_clr,
   output logic [CNT_W-1:0]     free_count,
   output logic                 full,
   output logic                 door_open
);

   localparam int HOLD_W = $clog2(DOOR_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DOOR_HOLD - 1);

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic [NUM_SPOTS-1:0]  spot_busy_q, spot_busy_d;

   logic                  free_valid_s;
   logic [SPOT_W-1:0]     free_idx_s;
   logic                  full_s;
   logic                  enter_cand_s;

   gate_scheduler_free_spot_enc u_free_spot_enc (
      .spot_busy_i (spot_busy_q),
      .valid_o     (free_valid_s),
      .index_o     (free_idx_s)
   );

   assign free_count = 3'(NUM_SPOTS) - popcount(spot_busy_q);
   assign full_s     = (popcount(spot_busy_q) == 3'(NUM_SPOTS));
   assign enter_cand_s = enter_req & ~full_s;

   // State, arbitration memory, door timer and occupancy register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_EXIT;
         hold_q       <= {HOLD_W{1'b0}};
         spot_busy_q  <= {NUM_SPOTS{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         hold_q       <= hold_d;
         spot_busy_q  <= spot_busy_d;
      end
   end

   // Next-state: on contention the side that did not win last time goes first.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      hold_d       = hold_q;
      spot_busy_d  = spot_busy_q;
      case (state_q)
         IDLE: begin
            if (enter_cand_s && exit_req) begin
               if (last_grant_q == GRANT_EXIT) begin
                  state_d      = G_ENTER;
                  last_grant_d = GRANT_ENTER;
               end else begin
                  state_d      = G_EXIT;
                  last_grant_d = GRANT_EXIT;
               end
            end else if (enter_cand_s) begin
               state_d      = G_ENTER;
               last_grant_d = GRANT_ENTER;
            end else if (exit_req) begin
               state_d      = G_EXIT;
               last_grant_d = GRANT_EXIT;
            end else begin
               state_d = IDLE;
            end
         end
         G_ENTER: begin
            if (free_valid_s) begin
               spot_busy_d[free_idx_s] = 1'b1;
            end else begin
               spot_busy_d = spot_busy_q;
            end
            state_d = DOOR;
            hold_d  = HOLD_LOAD;
         end
         G_EXIT: begin
            if (spot_busy_q[exit_spot]) begin
               spot_busy_d[exit_spot] = 1'b0;
               state_d = DOOR;
               hold_d  = HOLD_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         DOOR: begin
            if (hold_q == {HOLD_W{1'b0}}) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pulses and door level decode straight from the state flops.
   always_comb begin
      enter_ack     = 1'b0;
      exit_ack      = 1'b0;
      exit_err      = 1'b0;
      spot_clr      = {NUM_SPOTS{1'b0}};
      door_open     = 1'b0;
      assigned_spot = free_idx_s;
      case (state_q)
         G_ENTER: begin
            enter_ack = 1'b1;
            if (free_valid_s) begin
               spot_clr[free_idx_s] = 1'b1;
            end else begin
               spot_clr = {NUM_SPOTS{1'b0}};
            end
         end
         G_EXIT: begin
            exit_ack = 1'b1;
            exit_err = ~spot_busy_q[exit_spot];
         end
         DOOR: begin
            door_open = 1'b1;
         end
         default: begin
            door_open = 1'b0;
         end
      endcase
   end

   assign spot_busy = spot_busy_q;
   assign full      = full_s;

endmodule

// File: tb/tb_gate_scheduler.sv
// Scoreboard bench for gate_scheduler: directed requests, expected grants queued and checked by a monitor.
module tb_gate_scheduler;

   logic       CLK;
   logic       RST;
   logic       enter_req;
   logic       exit_req;
   logic [1:0] exit_spot;
   logic       enter_ack;
   logic [1:0] assigned_spot;
   logic       exit_ack;
   logic       exit_err;
   logic [3:0] spot_busy;
   logic [3:0] spot_clr;
   logic [2:0] free_count;
   logic       full;
   logic       door_open;

   typedef struct packed {
      logic       is_enter;
      logic [1:0] spot;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks;
   int   errors;
   int   ack_count;

   gate_scheduler #(.DOOR_HOLD(8)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .enter_req     (enter_req),
      .exit_req      (exit_req),
      .exit_spot     (exit_spot),
      .enter_ack     (enter_ack),
      .assigned_spot (assigned_spot),
      .exit_ack      (exit_ack),
      .exit_err      (exit_err),
      .spot_busy     (spot_busy),
      .spot_clr      (spot_clr),
      .free_count    (free_count),
      .full          (full),
      .door_open     (door_open)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every ack consumes the oldest expectation.
   always @(negedge CLK) begin
      if (!RST) begin
         if (enter_ack && exit_ack) chk("both_ack", 32'd1, 32'd0);
         if (enter_ack || exit_ack) begin
            ack_count++;
            chk("ack_door_low", 32'(door_open), 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("ack_kind", 32'(enter_ack), 32'(mon_e.is_enter));
               if (mon_e.is_enter) begin
                  chk("assigned_spot", 32'(assigned_spot), 32'(mon_e.spot));
                  chk("spot_clr", 32'(spot_clr), 32'(4'(4'b0001 << mon_e.spot)));
                  chk("enter_no_err", 32'(exit_err), 32'd0);
               end else begin
                  chk("exit_err", 32'(exit_err), 32'(mon_e.err));
                  chk("exit_no_clr", 32'(spot_clr), 32'd0);
               end
            end
         end else if (spot_clr !== 4'b0000 || exit_err !== 1'b0) begin
            chk("stray_pulse", 32'({spot_clr, exit_err}), 32'd0);
         end
      end
   end

   task automatic push_exp(input logic is_enter, input logic [1:0] spot, input logic err);
      exp_t e;
      e.is_enter = is_enter;
      e.spot     = spot;
      e.err      = err;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(output logic was_enter, output int cycles);
      logic got;
      got = 1'b0;
      was_enter = 1'b0;
      cycles = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         cycles = i + 1;
         if (enter_ack || exit_ack) begin
            got = 1'b1;
            was_enter = enter_ack;
            break;
         end
      end
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_door(output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (door_open) n++;
         else break;
      end
   endtask

   task automatic enter_one(input logic [1:0] spot);
      logic we;
      int   cyc;
      int   n;
      push_exp(1'b1, spot, 1'b0);
      @(posedge CLK); #1 enter_req = 1'b1;
      wait_ack(we, cyc);
      @(posedge CLK); #1 enter_req = 1'b0;
      count_door(n);
      chk("enter_door_cycles", 32'(n), 32'd8);
   endtask

   task automatic exit_one(input logic [1:0] spot);
      logic we;
      int   cyc;
      int   n;
      push_exp(1'b0, spot, 1'b0);
      @(posedge CLK); #1 exit_spot = spot; exit_req = 1'b1;
      wait_ack(we, cyc);
      @(posedge CLK); #1 exit_req = 1'b0;
      count_door(n);
      chk("exit_door_cycles", 32'(n), 32'd8);
   endtask

   initial begin
      logic we;
      int   cyc;
      int   n;
      int   a0;
      checks = 0;
      errors = 0;
      ack_count = 0;
      RST = 1'b1;
      enter_req = 1'b0;
      exit_req = 1'b0;
      exit_spot = 2'd0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_busy", 32'(spot_busy), 32'h0);
      chk("rst_free", 32'(free_count), 32'd4);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_door", 32'(door_open), 32'd0);

      // First entry gets spot 0.
      enter_one(2'd0);
      chk("t1_busy", 32'(spot_busy), 32'h1);
      chk("t1_free", 32'(free_count), 32'd3);

      // Exit of an empty spot: error, no door, occupancy unchanged.
      push_exp(1'b0, 2'd3, 1'b1);
      @(posedge CLK); #1 exit_spot = 2'd3; exit_req = 1'b1;
      wait_ack(we, cyc);
      @(posedge CLK); #1 exit_req = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (door_open) n++;
      end
      chk("err_no_door", 32'(n), 32'd0);
      chk("err_busy", 32'(spot_busy), 32'h1);

      // Fill the lot.
      enter_one(2'd1);
      enter_one(2'd2);
      enter_one(2'd3);
      chk("fill_busy", 32'(spot_busy), 32'hF);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_free", 32'(free_count), 32'd0);

      // Fifth car waits on a full lot.
      @(posedge CLK); #1 enter_req = 1'b1;
      a0 = ack_count;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (door_open) n++;
      end
      chk("full_no_ack", 32'(ack_count), 32'(a0));
      chk("full_no_door", 32'(n), 32'd0);

      // Exit of spot 2 goes first, then the waiting entry takes spot 2.
      push_exp(1'b0, 2'd2, 1'b0);
      push_exp(1'b1, 2'd2, 1'b0);
      @(posedge CLK); #1 exit_spot = 2'd2; exit_req = 1'b1;
      wait_ack(we, cyc);
      chk("contend_exit_first", 32'(we), 32'd0);
      @(posedge CLK); #1 exit_req = 1'b0;
      @(negedge CLK);
      chk("contend_busy", 32'(spot_busy), 32'hB);
      chk("contend_full_drop", 32'(full), 32'd0);
      wait_ack(we, cyc);
      chk("contend_enter_second", 32'(we), 32'd1);
      chk("contend_ack_gap", 32'(cyc + 1), 32'd10);
      @(posedge CLK); #1 enter_req = 1'b0;
      count_door(n);
      chk("contend_busy_after", 32'(spot_busy), 32'hF);

      // Free spots 0 and 1, then keep both requests pending: grants alternate.
      exit_one(2'd0);
      exit_one(2'd1);
      chk("alt_pre_busy", 32'(spot_busy), 32'hC);
      push_exp(1'b1, 2'd0, 1'b0);
      push_exp(1'b0, 2'd3, 1'b0);
      push_exp(1'b1, 2'd1, 1'b0);
      push_exp(1'b0, 2'd2, 1'b0);
      @(posedge CLK); #1 exit_spot = 2'd3; enter_req = 1'b1; exit_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_ack(we, cyc);
         chk("alt_order", 32'(we), 32'((k % 2) == 0));
         @(posedge CLK); #1;
         if (we) enter_req = 1'b0;
         else    exit_req = 1'b0;
         if (k < 2) begin
            @(posedge CLK); #1;
            if (we) begin
               enter_req = 1'b1;
            end else begin
               exit_spot = 2'd2;
               exit_req = 1'b1;
            end
         end
      end
      count_door(n);
      chk("alt_busy", 32'(spot_busy), 32'h3);

      // Reset in the middle of a door cycle.
      push_exp(1'b1, 2'd2, 1'b0);
      @(posedge CLK); #1 enter_req = 1'b1;
      wait_ack(we, cyc);
      @(posedge CLK); #1 enter_req = 1'b0;
      repeat (5) @(negedge CLK);
      chk("pre_rst_door", 32'(door_open), 32'd1);
      #1 RST = 1'b1;
      #1;
      chk("rst_mid_door", 32'(door_open), 32'd0);
      chk("rst_mid_busy", 32'(spot_busy), 32'h0);
      chk("rst_mid_free", 32'(free_count), 32'd4);
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_door", 32'(door_open), 32'd0);
      enter_one(2'd0);
      chk("post_rst_busy", 32'(spot_busy), 32'h1);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
